// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - command FIFO feeding an external ALU, with a registered result stage
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DW-1:0]                in_a,
  input  logic [DW-1:0]                in_b,
  input  logic [1:0]                   in_op,
  output logic [DW-1:0]                alu_a,
  output logic [DW-1:0]                alu_b,
  output logic [1:0]                   alu_op,
  input  logic [DW-1:0]                alu_y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DW-1:0]                out_y,
  output logic                         out_zero,
  output logic [1:0]                   out_op,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem_a  [DEPTH];
  logic [DW-1:0] mem_b  [DEPTH];
  logic [1:0]    mem_op [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          issue;
  logic          not_empty;

  assign not_empty = (count != '0);
  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign issue     = not_empty && (!out_valid || out_ready);

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]  <= in_a;
      mem_b[wr_ptr]  <= in_b;
      mem_op[wr_ptr] <= in_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 2'b00;
    if (not_empty) begin
      alu_a  = mem_a[rd_ptr];
      alu_b  = mem_b[rd_ptr];
      alu_op = mem_op[rd_ptr];
    end
  end

  // Result stage: load on issue, otherwise hold data and only retire valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_zero  <= 1'b0;
      out_op    <= 2'b00;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_y     <= alu_y;
      out_zero  <= (alu_y == '0);
      out_op    <= alu_op;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - directed self-checking bench for alu_issue_queue with an ALU model
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [1:0]    in_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_y;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_y;
  logic          out_zero;
  logic [1:0]    out_op;
  logic [2:0]    count;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  alu_issue_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero), .out_op(out_op),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  always_comb alu_y = alu_ref(alu_a, alu_b, alu_op);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [1:0] op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  // Scoreboarded cycle: model accepts on push, compares on each taken result.
  task automatic step();
    if (in_valid && in_ready) exp_q.push_back(alu_ref(in_a, in_b, in_op));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("s5_unexpected_result", 32'd1, 32'd0);
      end else begin
        check("s5_y", 32'(out_y), 32'(exp_q[0]));
        check("s5_zero", 32'(out_zero), 32'(exp_q[0] == '0));
        void'(exp_q.pop_front());
      end
    end
    tick();
  endtask

  logic [DW-1:0] s2_a [4] = '{8'h10, 8'h00, 8'hF0, 8'hA0};
  logic [DW-1:0] s2_b [4] = '{8'h10, 8'h01, 8'h0F, 8'h05};
  logic [1:0]    s2_op[4] = '{2'b01, 2'b01, 2'b10, 2'b11};
  logic [DW-1:0] s2_y [4] = '{8'h00, 8'hFF, 8'h00, 8'hA5};
  logic          s2_z [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int acc;
    int n;
    int cyc;
    logic acc_now;

    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_alu_a", 32'(alu_a), 32'd0);

    // 1: single ADD with one-edge issue latency
    out_ready = 1'b1;
    drive(1'b1, 8'h7F, 8'h01, 2'b00);
    tick();
    drive(1'b0, '0, '0, 2'b00);
    check("s1_no_bypass", 32'(out_valid), 32'd0);
    check("s1_count", 32'(count), 32'd1);
    check("s1_alu_a", 32'(alu_a), 32'h7F);
    tick();
    check("s1_out_valid", 32'(out_valid), 32'd1);
    check("s1_out_y", 32'(out_y), 32'h80);
    check("s1_out_zero", 32'(out_zero), 32'd0);
    check("s1_out_op", 32'(out_op), 32'd0);

    // 2: back-to-back commands, one result per cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, s2_a[i], s2_b[i], s2_op[i]);
      tick();
      if (i > 0) begin
        check("s2_valid", 32'(out_valid), 32'd1);
        check("s2_y", 32'(out_y), 32'(s2_y[i-1]));
        check("s2_zero", 32'(out_zero), 32'(s2_z[i-1]));
        check("s2_op", 32'(out_op), 32'(s2_op[i-1]));
      end
    end
    drive(1'b0, '0, '0, 2'b00);
    tick();
    check("s2_last_y", 32'(out_y), 32'hA5);
    check("s2_last_zero", 32'(out_zero), 32'd0);
    tick();
    check("s2_empty_valid", 32'(out_valid), 32'd0);

    // 3: stall with six push attempts
    out_ready = 1'b0;
    acc = 0;
    for (int j = 0; j < 6; j++) begin
      drive(1'b1, 8'(j + 1), 8'h10, 2'b00);
      if (in_ready) acc++;
      tick();
      if (j >= 1) check("s3_hold_y", 32'(out_y), 32'h11);
    end
    if (in_ready) acc++;
    tick();
    check("s3_accepted", 32'(acc), 32'd5);
    check("s3_count", 32'(count), 32'd4);
    check("s3_in_ready", 32'(in_ready), 32'd0);
    check("s3_stall_y", 32'(out_y), 32'h11);
    drive(1'b0, '0, '0, 2'b00);

    // 4: drain in acceptance order
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("s4_valid", 32'(out_valid), 32'd1);
      check("s4_y", 32'(out_y), 32'(8'h12 + 8'(k)));
      check("s4_count", 32'(count), 32'(3 - k));
    end
    tick();
    check("s4_valid_drop", 32'(out_valid), 32'd0);
    check("s4_hold_y", 32'(out_y), 32'h15);

    // 5: fill, then stream with simultaneous push/issue and pointer wrap
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h30 + 8'(17 * i), 8'hC0 - 8'(9 * i), 2'(i));
      step();
    end
    check("s5_full_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    n = 5;
    cyc = 0;
    while (n < 15 && cyc < 40) begin
      drive(1'b1, 8'h30 + 8'(17 * n), 8'hC0 - 8'(9 * n), 2'(n));
      acc_now = in_ready;
      step();
      if (acc_now) n++;
      cyc++;
      check("s5_count_steady", 32'(count), 32'd3);
    end
    check("s5_streamed", 32'(n), 32'd15);
    drive(1'b0, '0, '0, 2'b00);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      step();
      cyc++;
    end
    check("s5_drained", 32'(exp_q.size()), 32'd0);
    check("s5_final_count", 32'(count), 32'd0);
    check("s5_final_valid", 32'(out_valid), 32'd0);

    // 6: asynchronous reset mid-cycle
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h20 + 8'(i), 8'h01, 2'b00);
      tick();
    end
    drive(1'b0, '0, '0, 2'b00);
    check("s6_pre_count", 32'(count), 32'd3);
    check("s6_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("s6_async_valid", 32'(out_valid), 32'd0);
    check("s6_async_count", 32'(count), 32'd0);
    check("s6_async_y", 32'(out_y), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 8'h01, 8'h02, 2'b00);
    tick();
    drive(1'b0, '0, '0, 2'b00);
    check("s6_no_stale", 32'(out_valid), 32'd0);
    check("s6_count", 32'(count), 32'd1);
    tick();
    check("s6_valid", 32'(out_valid), 32'd1);
    check("s6_y", 32'(out_y), 32'h03);
    check("s6_op", 32'(out_op), 32'd0);
    tick();
    check("s6_done", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
